chien_search_pp: RTL and testbench



---
 rtl/chien_pp_pkg.sv | 55 +++++
 rtl/chien_lane.sv | 27 ++
 rtl/chien_search_pp.sv | 198 +++++++++++++++++++
 tb/tb_chien_search_pp.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chien_pp_pkg.sv
// Shared types, sizes and GF(2^W) helpers for the parallel Chien search.
// Field polynomial x^10+x^3+1, primitive element alpha = 2.
package chien_pp_pkg;

  localparam int W     = 10;
  localparam int T     = 11;
  localparam int P     = 32;
  localparam int N     = (1 << W) - 1;
  localparam int NLEN  = 544;
  localparam int BATCH = (NLEN + P - 1) / P;
  localparam int PW    = $clog2(NLEN);
  localparam int CW    = $clog2(T + 1) + 1;
  localparam int BW    = $clog2(BATCH);

  localparam logic [W:0] POLY = 11'h409;

  typedef logic [W-1:0] sym_t;
  typedef sym_t sigma_t [0:T];

  typedef enum logic {
    S_IDLE,
    S_SCAN
  } state_e;

  // a * c; c is an elaboration constant, so this folds to an XOR network.
  function automatic sym_t gf_cmul(sym_t a, sym_t c);
    sym_t acc;
    sym_t m;
    acc = '0;
    m   = a;
    for (int i = 0; i < W; i++) begin
      if (c[i]) acc = acc ^ m;
      m = m[W-1] ? ((m << 1) ^ POLY[W-1:0]) : (m << 1);
    end
    return acc;
  endfunction

  // alpha^(-e) by repeated division by alpha (x^-1 = x^9 + x^2).
  function automatic sym_t gf_pow_inv(int e);
    sym_t x;
    x = sym_t'(1);
    for (int i = 0; i < e % N; i++)
      x = x[0] ? ((x >> 1) ^ POLY[W:1]) : (x >> 1);
    return x;
  endfunction

  function automatic logic [CW-1:0] deg_of(sigma_t s);
    logic [CW-1:0] d;
    d = '0;
    for (int k = 0; k <= T; k++)
      if (s[k] != '0) d = CW'(k);
    return d;
  endfunction

endpackage

// File: rtl/chien_lane.sv
// One Chien lane: zero_o = (sum_k r_i[k] * alpha^(-k*LANE) == 0).
// Ports: r_i working registers R_0..R_T, zero_o lane value is zero.
module chien_lane
  import chien_pp_pkg::*;
#(
  parameter int LANE = 0
) (
  input  sigma_t r_i,
  output logic   zero_o
);

  sym_t term [0:T];
  sym_t acc;

  for (genvar k = 0; k <= T; k++) begin : g_term
    localparam sym_t C = gf_pow_inv(k * LANE);
    assign term[k] = gf_cmul(r_i[k], C);
  end

  always_comb begin
    acc = '0;
    for (int k = 0; k <= T; k++) acc = acc ^ term[k];
  end

  assign zero_o = (acc == '0);

endmodule

// File: rtl/chien_search_pp.sv
// Parallel Chien search with ping-pong shadow for the next Lambda.
// Ports: clk_i/rst_i, sigma_* handshake in, batch stream + done/err/fail out.
module chien_search_pp
  import chien_pp_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [(T+1)*W-1:0]   sigma_i,
  input  logic                 sigma_valid_i,
  output logic                 sigma_ready_o,
  output logic                 batch_valid_o,
  output logic [P-1:0]         hit_mask_o,
  output logic [P*PW-1:0]      pos_bus_o,
  output logic                 last_o,
  output logic                 done_o,
  output logic [CW-1:0]        err_cnt_o,
  output logic                 fail_o
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  state_e          state_q, state_d;
  logic [BW-1:0]   batch_q, batch_d;
  logic            f_q, f_d;
  sigma_t          r_q, r_d, sh_q, sh_d, r_next, sig_in;
  logic [CW-1:0]   deg_q, deg_d, deg_sh_q, deg_sh_d;
  logic            z_q, z_d, z_sh_q, z_sh_d;
  logic [CW-1:0]   acc_q, acc_d;
  logic            bv_q, bv_d, last_q, last_d, done_q, done_d;
  logic [P-1:0]    hit_q, hit_d;
  logic [P*PW-1:0] pos_q, pos_d;
  logic [CW-1:0]   err_q, err_d;
  logic            fail_q, fail_d;

  logic [P-1:0]    zero_w, hit_now;
  logic [P*PW-1:0] pos_now;
  logic [7:0]      pop_w, sum_w;
  logic [CW-1:0]   sat_w, in_deg;
  logic            in_z, accept, is_last;
  int              jbase_w;

  always_comb begin
    for (int k = 0; k <= T; k++) sig_in[k] = sigma_i[k*W +: W];
  end

  assign in_deg  = deg_of(sig_in);
  assign in_z    = (sig_in[0] == '0);
  assign accept  = sigma_valid_i & ~f_q;
  assign is_last = (batch_q == BW'(BATCH - 1));
  assign jbase_w = int'(batch_q) * P;

  // Step to the next batch: R_k <- R_k * alpha^(-kP).
  for (genvar k = 0; k <= T; k++) begin : g_upd
    localparam sym_t U = gf_pow_inv(k * P);
    assign r_next[k] = gf_cmul(r_q[k], U);
  end

  for (genvar t = 0; t < P; t++) begin : g_lane
    chien_lane #(.LANE(t)) u_lane (
      .r_i   (r_q),
      .zero_o(zero_w[t])
    );
  end

  // Lanes past the shortened length are forced quiet.
  always_comb begin
    hit_now = '0;
    pos_now = '0;
    for (int t = 0; t < P; t++) begin
      if (jbase_w + t < NLEN) begin
        hit_now[t]          = zero_w[t];
        pos_now[t*PW +: PW] = PW'(NLEN - 1 - jbase_w - t);
      end
    end
  end

  always_comb begin
    pop_w = '0;
    for (int t = 0; t < P; t++) pop_w = pop_w + 8'(hit_now[t]);
  end

  assign sum_w = ((batch_q == '0) ? 8'd0 : 8'(acc_q)) + pop_w;
  assign sat_w = (sum_w > 8'(CNT_MAX)) ? CNT_MAX : sum_w[CW-1:0];

  always_comb begin
    state_d  = state_q;
    batch_d  = batch_q;
    f_d      = f_q;
    r_d      = r_q;
    sh_d     = sh_q;
    deg_d    = deg_q;
    z_d      = z_q;
    deg_sh_d = deg_sh_q;
    z_sh_d   = z_sh_q;
    acc_d    = acc_q;
    bv_d     = 1'b0;
    hit_d    = '0;
    pos_d    = '0;
    last_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = err_q;
    fail_d   = fail_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          r_d     = sig_in;
          deg_d   = in_deg;
          z_d     = in_z;
          batch_d = '0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        bv_d    = 1'b1;
        hit_d   = hit_now;
        pos_d   = pos_now;
        acc_d   = sat_w;
        r_d     = r_next;
        batch_d = batch_q + 1'b1;
        if (is_last) begin
          last_d  = 1'b1;
          done_d  = 1'b1;
          err_d   = sat_w;
          fail_d  = (sat_w != deg_q) | z_q;
          batch_d = '0;
          if (f_q) begin
            r_d   = sh_q;
            deg_d = deg_sh_q;
            z_d   = z_sh_q;
            f_d   = 1'b0;
          end else if (accept) begin
            r_d   = sig_in;
            deg_d = in_deg;
            z_d   = in_z;
          end else begin
            state_d = S_IDLE;
          end
        end else if (accept) begin
          sh_d     = sig_in;
          deg_sh_d = in_deg;
          z_sh_d   = in_z;
          f_d      = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      batch_q  <= '0;
      f_q      <= 1'b0;
      r_q      <= '{default: '0};
      sh_q     <= '{default: '0};
      deg_q    <= '0;
      z_q      <= 1'b0;
      deg_sh_q <= '0;
      z_sh_q   <= 1'b0;
      acc_q    <= '0;
      bv_q     <= 1'b0;
      hit_q    <= '0;
      pos_q    <= '0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= '0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      batch_q  <= batch_d;
      f_q      <= f_d;
      r_q      <= r_d;
      sh_q     <= sh_d;
      deg_q    <= deg_d;
      z_q      <= z_d;
      deg_sh_q <= deg_sh_d;
      z_sh_q   <= z_sh_d;
      acc_q    <= acc_d;
      bv_q     <= bv_d;
      hit_q    <= hit_d;
      pos_q    <= pos_d;
      last_q   <= last_d;
      done_q   <= done_d;
      err_q    <= err_d;
      fail_q   <= fail_d;
    end
  end

  assign sigma_ready_o = ~f_q;
  assign batch_valid_o = bv_q;
  assign hit_mask_o    = hit_q;
  assign pos_bus_o     = pos_q;
  assign last_o        = last_q;
  assign done_o        = done_q;
  assign err_cnt_o     = err_q;
  assign fail_o        = fail_q;

endmodule

// File: tb/tb_chien_search_pp.sv
// Bench for chien_search_pp: direct polynomial-evaluation model + scoreboard.
// Accept edge e = posedge sampling valid&ready; batch 0 seen after edge e+1.
`timescale 1ns/1ps
module tb_chien_search_pp;
  import chien_pp_pkg::*;

  logic                clk, rst_i;
  logic [(T+1)*W-1:0]  sigma_i;
  logic                sigma_valid_i, sigma_ready_o;
  logic                batch_valid_o, last_o, done_o, fail_o;
  logic [P-1:0]        hit_mask_o;
  logic [P*PW-1:0]     pos_bus_o;
  logic [CW-1:0]       err_cnt_o;

  chien_search_pp dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .sigma_i      (sigma_i),
    .sigma_valid_i(sigma_valid_i),
    .sigma_ready_o(sigma_ready_o),
    .batch_valid_o(batch_valid_o),
    .hit_mask_o   (hit_mask_o),
    .pos_bus_o    (pos_bus_o),
    .last_o       (last_o),
    .done_o       (done_o),
    .err_cnt_o    (err_cnt_o),
    .fail_o       (fail_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int              cyc;
    logic [P-1:0]    hit;
    logic [P*PW-1:0] pos;
    logic            last;
    int              err;
    int              fail;
  } exp_t;

  exp_t exp_q[$];
  int   gexp [0:N-1];
  int   glog [0:N];
  int   checks = 0, errors = 0;
  int   cyc = 0, last_end = -100;
  int   nb = 0, nd = 0;
  int   m_err, m_fail, m_first, m_lend;
  int   m_hits[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_i(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_v(input string nm, input logic [P*PW-1:0] act,
                       input logic [P*PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic int gmul(int a, int b);
    if (a == 0 || b == 0) return 0;
    return gexp[(glog[a] + glog[b]) % N];
  endfunction

  function automatic int ainv(int j);
    return gexp[(N - (j % N)) % N];
  endfunction

  // Evaluate Lambda(alpha^-j) for every position and lay out the stream.
  task automatic model_push(input int lam [0:T], input int acc_edge);
    int   start, deg, cnt, v, x, xp, j, sat;
    exp_t e;
    deg = 0;
    for (int k = 0; k <= T; k++) if (lam[k] != 0) deg = k;
    start = acc_edge + 1;
    if (last_end + 1 > start) start = last_end + 1;
    cnt = 0;
    m_hits.delete();
    for (int b = 0; b < BATCH; b++) begin
      e.cyc  = start + b;
      e.hit  = '0;
      e.pos  = '0;
      e.last = (b == BATCH - 1);
      e.err  = 0;
      e.fail = 0;
      for (int t = 0; t < P; t++) begin
        j = b * P + t;
        if (j < NLEN) begin
          x  = ainv(j);
          v  = 0;
          xp = 1;
          for (int k = 0; k <= T; k++) begin
            v  = v ^ gmul(lam[k], xp);
            xp = gmul(xp, x);
          end
          e.pos[t*PW +: PW] = PW'(NLEN - 1 - j);
          if (v == 0) begin
            e.hit[t] = 1'b1;
            cnt++;
            m_hits.push_back(NLEN - 1 - j);
          end
        end
      end
      sat = (cnt > (1 << CW) - 1) ? (1 << CW) - 1 : cnt;
      if (e.last) begin
        e.err  = sat;
        e.fail = (sat != deg || lam[0] == 0) ? 1 : 0;
        m_err  = e.err;
        m_fail = e.fail;
      end
      exp_q.push_back(e);
    end
    m_first  = start;
    last_end = start + BATCH - 1;
    m_lend   = last_end;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (batch_valid_o) nb++;
    if (done_o) nd++;
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      chk_i("batch_valid", int'(batch_valid_o), 1);
      chk_i("hit_mask", int'(hit_mask_o), int'(e.hit));
      chk_v("pos_bus", pos_bus_o, e.pos);
      chk_i("last", int'(last_o), int'(e.last));
      chk_i("done", int'(done_o), int'(e.last));
      if (e.last) begin
        chk_i("err_cnt", int'(err_cnt_o), e.err);
        chk_i("fail", int'(fail_o), e.fail);
      end
    end else begin
      chk_i("idle_valid", int'(batch_valid_o), 0);
      chk_i("idle_hit", int'(hit_mask_o), 0);
      chk_v("idle_pos", pos_bus_o, '0);
      chk_i("idle_last", int'(last_o), 0);
      chk_i("idle_done", int'(done_o), 0);
    end
  end

  task automatic offer(input int lam [0:T], output int edge_o);
    int n = 0;
    @(negedge clk);
    for (int k = 0; k <= T; k++) sigma_i[k*W +: W] = W'(lam[k]);
    sigma_valid_i = 1'b1;
    while (!sigma_ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk_i("ready_timeout", int'(sigma_ready_o), 1);
    edge_o = cyc + 1;
    model_push(lam, edge_o);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk_i("drain", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  function automatic void clr(output int l [0:T]);
    for (int k = 0; k <= T; k++) l[k] = 0;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int l0 [0:T], l1 [0:T], l2 [0:T], l3 [0:T];
    int e, e1, e2, e3, nb0, nd0, a, b;
    rst_i         = 1'b1;
    sigma_valid_i = 1'b0;
    sigma_i       = '0;
    gexp[0] = 1;
    for (int i = 1; i < N; i++) begin
      gexp[i] = gexp[i-1] << 1;
      if (gexp[i] >= (1 << W)) gexp[i] = gexp[i] ^ int'(POLY);
    end
    glog[0] = 0;
    for (int i = 0; i < N; i++) glog[gexp[i]] = i;

    repeat (3) @(negedge clk);
    chk_i("rst_valid", int'(batch_valid_o), 0);
    chk_i("rst_ready", int'(sigma_ready_o), 1);
    chk_i("rst_err", int'(err_cnt_o), 0);
    chk_i("rst_fail", int'(fail_o), 0);
    rst_i = 1'b0;

    // deg 0: no roots, clean.
    clr(l0); l0[0] = 1;
    offer(l0, e);
    sigma_valid_i = 1'b0;
    chk_i("m0_err", m_err, 0);
    chk_i("m0_fail", m_fail, 0);
    chk_i("m0_lastcyc", m_lend, e + 17);
    drain();

    // single root at j = 5.
    clr(l1); l1[0] = 1; l1[1] = gexp[5];
    offer(l1, e);
    sigma_valid_i = 1'b0;
    chk_i("m1_err", m_err, 1);
    chk_i("m1_nh", m_hits.size(), 1);
    chk_i("m1_pos", m_hits[0], 538);
    drain();

    // roots at both ends of the shortened code.
    clr(l2); l2[0] = 1; l2[1] = 1 ^ gexp[543]; l2[2] = gexp[543];
    offer(l2, e);
    sigma_valid_i = 1'b0;
    chk_i("m2_err", m_err, 2);
    chk_i("m2_fail", m_fail, 0);
    chk_i("m2_pos0", m_hits[0], 543);
    chk_i("m2_pos1", m_hits[1], 0);
    drain();

    // roots only beyond the shortened length.
    a = gexp[600]; b = gexp[700];
    clr(l3); l3[0] = 1; l3[1] = a ^ b; l3[2] = gmul(a, b);
    offer(l3, e);
    sigma_valid_i = 1'b0;
    chk_i("m3_err", m_err, 0);
    chk_i("m3_fail", m_fail, 1);
    drain();

    // back-to-back with valid held high.
    nb0 = nb; nd0 = nd;
    offer(l2, e1);
    offer(l3, e2);
    offer(l1, e3);
    sigma_valid_i = 1'b0;
    chk_i("b2b_acc2", e2, e1 + 1);
    chk_i("b2b_acc3", e3, e1 + 18);
    drain();
    chk_i("b2b_batches", nb - nb0, 51);
    chk_i("b2b_dones", nd - nd0, 3);

    // async reset at batch 8 with the shadow full.
    offer(l2, e1);
    offer(l3, e2);
    sigma_valid_i = 1'b0;
    while (cyc < e1 + 1 + 8) @(negedge clk);
    #2 rst_i = 1'b1;
    #1;
    chk_i("ar_valid", int'(batch_valid_o), 0);
    chk_i("ar_hit", int'(hit_mask_o), 0);
    chk_v("ar_pos", pos_bus_o, '0);
    chk_i("ar_last", int'(last_o), 0);
    chk_i("ar_done", int'(done_o), 0);
    chk_i("ar_err", int'(err_cnt_o), 0);
    chk_i("ar_fail", int'(fail_o), 0);
    chk_i("ar_ready", int'(sigma_ready_o), 1);
    exp_q.delete();
    last_end = -100;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    nd0 = nd;
    offer(l1, e);
    sigma_valid_i = 1'b0;
    drain();
    chk_i("post_rst_dones", nd - nd0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
